// File: rtl/motoro3_pwm_pkg.sv
// Shared constants and saturating arithmetic for the multi-channel motor PWM.
package motoro3_pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int NCH_DEF   = 3;
  localparam int CNT_W_DEF = 12;
  localparam int POS_W_DEF = 16;

  // Unsigned a+b clamped to 2^w-1 (w <= 31).
  function automatic logic [31:0] sat_add_u(input logic [31:0] a, input logic [31:0] b,
                                            input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return 32'((sum > lim) ? lim : sum);
  endfunction

  // Signed a-b of two unsigned w-bit values, clamped to the signed w-bit range.
  function automatic logic signed [31:0] sat_sub_s(input logic [31:0] a, input logic [31:0] b,
                                                   input int w);
    logic signed [33:0] d;
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    logic signed [33:0] r;
    d  = $signed({2'b00, a}) - $signed({2'b00, b});
    hi = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo = -hi - 34'sd1;
    r  = (d > hi) ? hi : ((d < lo) ? lo : d);
    return 32'(r);
  endfunction

endpackage

// File: rtl/motoro3_pwm_multi_if.sv
// Control/status bundle between the step sequencer, the PWM generator and the gate drivers.
interface motoro3_pwm_multi_if #(
  parameter int NCH   = 3,
  parameter int CNT_W = 12,
  parameter int POS_W = 16
);
  logic                 en;
  logic [CNT_W-1:0]     period_len;
  logic [CNT_W-1:0]     min_on;
  logic                 center_mode;
  logic                 step_first;
  logic                 step_last;
  logic [NCH*POS_W-1:0] duty_pos;
  logic [NCH-1:0]       pwm_out;
  logic                 period_start;
  logic [NCH*POS_W-1:0] lost;
  logic                 lost_valid;

  modport master (
    output en, period_len, min_on, center_mode, step_first, step_last, duty_pos,
    input  pwm_out, period_start, lost, lost_valid
  );

  modport slave (
    input  en, period_len, min_on, center_mode, step_first, step_last, duty_pos,
    output pwm_out, period_start, lost, lost_valid
  );
endinterface

// File: rtl/motoro3_pwm_chan.sv
// One PWM channel: duty carry-over with min-on deferral, window compare, output
// register and want/real on-time accounting.
module motoro3_pwm_chan
  import motoro3_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    start_i,
  input  logic                    trunc_i,
  input  logic                    snap_i,
  input  logic                    center_i,
  input  logic [CNT_W-1:0]        cnt_i,
  input  logic [CNT_W-1:0]        plen_i,
  input  logic [CNT_W-1:0]        min_on_i,
  input  logic [POS_W-1:0]        duty_i,
  output logic                    pwm_o,
  output logic signed [POS_W-1:0] lost_o
);
  logic [POS_W-1:0]        remain_q, remain_d, want_q, want_d, real_q, real_d;
  logic [CNT_W-1:0]        on_len_q, on_len_d;
  logic                    pwm_q, pwm_d;
  logic signed [POS_W-1:0] lost_q, lost_d;

  logic [POS_W-1:0] demand, remain_new, remain_cur;
  logic [CNT_W-1:0] on_new, on_cur, s, delivered;
  logic [CNT_W:0]   s_end;

  always_comb begin
    demand = POS_W'(sat_add_u(32'(remain_q), 32'(duty_i), POS_W));
    on_new = '0;
    remain_new = demand;
    if ((32'(demand) >= 32'(min_on_i)) && (demand != '0)) begin
      on_new     = (32'(demand) < 32'(plen_i)) ? CNT_W'(demand) : plen_i;
      remain_new = demand - POS_W'(on_new);
    end
    // The period-start cycle already drives the window from the fresh on_len.
    on_cur     = start_i ? on_new : on_len_q;
    remain_cur = start_i ? remain_new : remain_q;

    s     = (center_i == MODE_CENTER) ? ((plen_i - on_cur) >> 1) : '0;
    s_end = {1'b0, s} + {1'b0, on_cur};
    if (cnt_i < s)                 delivered = '0;
    else if ((cnt_i - s) < on_cur) delivered = cnt_i - s;
    else                           delivered = on_cur;

    on_len_d = on_cur;
    pwm_d    = en_i && !trunc_i && (cnt_i >= s) && ({1'b0, cnt_i} < s_end);
    remain_d = remain_cur;
    if (trunc_i) remain_d = POS_W'(sat_add_u(32'(remain_cur), 32'(on_cur - delivered), POS_W));
    want_d = start_i ? POS_W'(sat_add_u(32'(want_q), 32'(duty_i), POS_W)) : want_q;
    real_d = POS_W'(sat_add_u(32'(real_q), 32'(pwm_q), POS_W));
    lost_d = lost_q;
    // The snapshot sees this cycle's demand and output before clearing.
    if (snap_i) begin
      lost_d   = POS_W'(sat_sub_s(32'(want_d), 32'(real_d), POS_W));
      want_d   = '0;
      real_d   = '0;
      remain_d = '0;
    end
    if (!en_i) remain_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= '0;
      on_len_q <= '0;
      want_q   <= '0;
      real_q   <= '0;
      pwm_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      remain_q <= remain_d;
      on_len_q <= on_len_d;
      want_q   <= want_d;
      real_q   <= real_d;
      pwm_q    <= pwm_d;
      lost_q   <= lost_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign lost_o = lost_q;
endmodule

// File: rtl/motoro3_pwm_multi.sv
// NCH-channel PWM generator: shared period counter, step decode and enable gating
// feeding one motoro3_pwm_chan per phase.
module motoro3_pwm_multi
  import motoro3_pwm_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input logic                clk,
  input logic                rst,
  motoro3_pwm_multi_if.slave bus
);
  logic [CNT_W-1:0]     cnt_q, cnt_d, plen_q, plen_d;
  logic                 center_q, center_d;
  logic                 lost_valid_q;
  logic                 start, trunc, snap;
  logic [NCH-1:0]       pwm_w;
  logic [NCH*POS_W-1:0] lost_w;

  always_comb begin
    start    = bus.en && (cnt_q == '0);
    trunc    = bus.en && bus.step_last;
    snap     = bus.en && bus.step_first;
    plen_d   = plen_q;
    center_d = center_q;
    if (start) begin
      plen_d   = (bus.period_len < CNT_W'(2)) ? CNT_W'(2) : bus.period_len;
      center_d = bus.center_mode;
    end
    cnt_d = cnt_q + 1'b1;
    if (!bus.en || trunc || (cnt_q == plen_d - 1'b1)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      plen_q       <= CNT_W'(2);
      center_q     <= MODE_EDGE;
      lost_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      plen_q       <= plen_d;
      center_q     <= center_d;
      lost_valid_q <= snap;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    motoro3_pwm_chan #(
      .CNT_W(CNT_W),
      .POS_W(POS_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en_i     (bus.en),
      .start_i  (start),
      .trunc_i  (trunc),
      .snap_i   (snap),
      .center_i (center_d),
      .cnt_i    (cnt_q),
      .plen_i   (plen_d),
      .min_on_i (bus.min_on),
      .duty_i   (bus.duty_pos[k*POS_W +: POS_W]),
      .pwm_o    (pwm_w[k]),
      .lost_o   (lost_w[k*POS_W +: POS_W])
    );
  end

  assign bus.pwm_out      = pwm_w;
  assign bus.lost         = lost_w;
  assign bus.period_start = start;
  assign bus.lost_valid   = lost_valid_q;
endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// Directed bench for motoro3_pwm_multi: per-period pulse tables plus step/enable/reset sequences.
module tb_motoro3_pwm_multi;
  import motoro3_pwm_pkg::*;

  localparam int NCH   = 3;
  localparam int CNT_W = 12;
  localparam int POS_W = 16;
  localparam int NVEC  = 8;

  typedef logic [5:0][7:0] arr6_t;
  typedef struct packed {
    logic [11:0] plen_in;
    logic [11:0] min_on;
    logic        center;
    logic [15:0] duty;
    logic [2:0]  nper;
    arr6_t       exp_cnt;
    arr6_t       exp_first;
    arr6_t       exp_last;
  } vec_t;

  logic clk, rst;
  motoro3_pwm_multi_if #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();
  motoro3_pwm_multi #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec, n_bad;
  vec_t vecs [NVEC];
  int   hc [NCH][6];
  int   hf [NCH][6];
  int   hl [NCH][6];
  int   cntp [NCH];

  function automatic arr6_t a6(input int p0, p1, p2, p3, p4, p5);
    return {8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    bus.step_first = 1'b0;
    bus.step_last = 1'b0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic cfg(input int plen, input int mn, input logic ctr, input int d0, d1, d2);
    bus.period_len  = CNT_W'(plen);
    bus.min_on      = CNT_W'(mn);
    bus.center_mode = ctr;
    bus.duty_pos    = {POS_W'(d2), POS_W'(d1), POS_W'(d0)};
  endtask

  task automatic run_count(input int n);
    for (int c = 0; c < NCH; c++) cntp[c] = 0;
    repeat (n) begin
      step();
      for (int c = 0; c < NCH; c++) if (bus.pwm_out[c]) cntp[c]++;
    end
  endtask

  task automatic pulse_snap(input logic also_last);
    bus.step_first = 1'b1;
    bus.step_last  = also_last;
    step();
    bus.step_first = 1'b0;
    bus.step_last  = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   plen, nper, per, off, ps;

    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.step_first = 1'b0;
    bus.step_last = 1'b0;
    cfg(100, 32, MODE_EDGE, 0, 0, 0);

    //                plen  min  mode         duty  n    high counts                first offset            last offset
    vecs[0] = '{12'd100, 12'd32, MODE_EDGE,   16'd40,  3'd3, a6(40,40,40,0,0,0),     a6(1,1,1,0,0,0),      a6(40,40,40,0,0,0)};
    vecs[1] = '{12'd100, 12'd32, MODE_EDGE,   16'd10,  3'd4, a6(0,0,0,40,0,0),       a6(0,0,0,1,0,0),      a6(0,0,0,40,0,0)};
    vecs[2] = '{12'd100, 12'd32, MODE_EDGE,   16'd150, 3'd3, a6(100,100,100,0,0,0),  a6(1,1,1,0,0,0),      a6(100,100,100,0,0,0)};
    vecs[3] = '{12'd100, 12'd32, MODE_CENTER, 16'd40,  3'd3, a6(40,40,40,0,0,0),     a6(31,31,31,0,0,0),   a6(70,70,70,0,0,0)};
    vecs[4] = '{12'd50,  12'd80, MODE_EDGE,   16'd30,  3'd5, a6(0,0,50,0,50,0),      a6(0,0,1,0,1,0),      a6(0,0,50,0,50,0)};
    vecs[5] = '{12'd1,   12'd0,  MODE_EDGE,   16'd1,   3'd4, a6(1,1,1,1,0,0),        a6(1,1,1,1,0,0),      a6(1,1,1,1,0,0)};
    vecs[6] = '{12'd100, 12'd0,  MODE_EDGE,   16'd0,   3'd3, a6(0,0,0,0,0,0),        a6(0,0,0,0,0,0),      a6(0,0,0,0,0,0)};
    vecs[7] = '{12'd10,  12'd0,  MODE_CENTER, 16'd3,   3'd3, a6(3,3,3,0,0,0),        a6(4,4,4,0,0,0),      a6(6,6,6,0,0,0)};

    do_reset();
    chk("rst_pwm", 64'(bus.pwm_out), 64'd0);
    chk("rst_lost", 64'(bus.lost), 64'd0);
    chk("rst_lost_valid", 64'(bus.lost_valid), 64'd0);
    chk("rst_period_start", 64'(bus.period_start), 64'd0);

    for (int r = 0; r < NVEC; r++) begin
      v    = vecs[r];
      plen = (v.plen_in < 12'd2) ? 2 : int'(v.plen_in);
      nper = int'(v.nper);
      cfg(int'(v.plen_in), int'(v.min_on), v.center, int'(v.duty), int'(v.duty), int'(v.duty));
      do_reset();
      bus.en = 1'b1;
      #1;
      chk($sformatf("r%0d_start0", r), 64'(bus.period_start), 64'd1);
      for (int c = 0; c < NCH; c++)
        for (int p = 0; p < 6; p++) begin
          hc[c][p] = 0; hf[c][p] = 0; hl[c][p] = 0;
        end
      ps = 0;
      for (int i = 1; i <= nper * plen; i++) begin
        step();
        per = (i - 1) / plen;
        off = (i - 1) % plen + 1;
        for (int c = 0; c < NCH; c++)
          if (bus.pwm_out[c]) begin
            hc[c][per]++;
            if (hf[c][per] == 0) hf[c][per] = off;
            hl[c][per] = off;
          end
        if (bus.period_start) ps++;
      end
      chk($sformatf("r%0d_period_starts", r), 64'(ps), 64'(nper));
      for (int c = 0; c < NCH; c++)
        for (int p = 0; p < nper; p++) begin
          chk($sformatf("r%0d_ch%0d_p%0d_high", r, c, p), 64'(hc[c][p]), 64'(v.exp_cnt[p]));
          chk($sformatf("r%0d_ch%0d_p%0d_first", r, c, p), 64'(hf[c][p]), 64'(v.exp_first[p]));
          chk($sformatf("r%0d_ch%0d_p%0d_last", r, c, p), 64'(hl[c][p]), 64'(v.exp_last[p]));
        end
      bus.en = 1'b0;
    end

    // step_last at cnt=20 with 20 cycles delivered: 40 refunded into the next period
    cfg(100, 32, MODE_EDGE, 60, 60, 60);
    do_reset();
    bus.en = 1'b1;
    steps(20);
    chk("trunc_pre_high", 64'(bus.pwm_out), 64'h7);
    bus.step_last = 1'b1;
    step();
    bus.step_last = 1'b0;
    #1;
    chk("trunc_low", 64'(bus.pwm_out), 64'h0);
    chk("trunc_period_start", 64'(bus.period_start), 64'd1);
    run_count(100);
    for (int c = 0; c < NCH; c++) chk($sformatf("trunc_refund_ch%0d", c), 64'(cntp[c]), 64'd100);
    run_count(100);
    for (int c = 0; c < NCH; c++) chk($sformatf("trunc_after_ch%0d", c), 64'(cntp[c]), 64'd60);

    // 3 periods of 50, then step_first+step_last together at cnt=10 of period 4
    cfg(100, 32, MODE_EDGE, 50, 50, 50);
    do_reset();
    bus.en = 1'b1;
    steps(310);
    chk("both_pre_high", 64'(bus.pwm_out), 64'h7);
    pulse_snap(1'b1);
    chk("both_lost", 64'(bus.lost), 64'({3{16'd40}}));
    chk("both_lost_valid", 64'(bus.lost_valid), 64'd1);
    chk("both_pwm_low", 64'(bus.pwm_out), 64'h0);
    chk("both_period_start", 64'(bus.period_start), 64'd1);
    step();
    chk("both_lost_valid_end", 64'(bus.lost_valid), 64'd0);
    steps(59);
    pulse_snap(1'b0);
    chk("clear_lost_zero", 64'(bus.lost), 64'd0);
    steps(49);
    pulse_snap(1'b0);
    chk("snap_pos40", 64'(bus.lost), 64'({3{16'd40}}));
    steps(49);
    pulse_snap(1'b0);
    chk("snap_neg40", 64'(bus.lost), 64'({3{16'hFFD8}}));

    // lost saturates positive; reset mid-pulse clears every output
    cfg(100, 32, MODE_EDGE, 16'hFFFF, 0, 0);
    do_reset();
    bus.en = 1'b1;
    steps(50);
    chk("sat_pre_high", 64'(bus.pwm_out), 64'h1);
    pulse_snap(1'b0);
    chk("sat_lost", 64'(bus.lost), 64'({16'd0, 16'd0, 16'h7FFF}));
    steps(70);
    chk("midrst_pre_high", 64'(bus.pwm_out), 64'h1);
    rst = 1'b1;
    bus.en = 1'b0;
    step();
    chk("midrst_pwm", 64'(bus.pwm_out), 64'h0);
    chk("midrst_lost", 64'(bus.lost), 64'd0);
    chk("midrst_lost_valid", 64'(bus.lost_valid), 64'd0);
    chk("midrst_period_start", 64'(bus.period_start), 64'd0);
    rst = 1'b0;

    // en drop mid-pulse, then restart with a fresh period
    cfg(100, 32, MODE_EDGE, 40, 40, 40);
    bus.en = 1'b1;
    steps(10);
    chk("en_pre_high", 64'(bus.pwm_out), 64'h7);
    bus.en = 1'b0;
    step();
    chk("en_off_pwm", 64'(bus.pwm_out), 64'h0);
    chk("en_off_period_start", 64'(bus.period_start), 64'd0);
    bus.en = 1'b1;
    #1;
    chk("en_on_period_start", 64'(bus.period_start), 64'd1);
    step();
    chk("en_on_first_high", 64'(bus.pwm_out), 64'h7);
    run_count(99);
    for (int c = 0; c < NCH; c++) chk($sformatf("en_on_rest_ch%0d", c), 64'(cntp[c]), 64'd39);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
